// File: rtl/period_meter_if.sv
// Signal bundle between a slow square-wave source and period_meter.
// high_out is present only when PERIOD_METER_HIGH_EN is defined.
interface period_meter_if #(
  parameter int unsigned CNT_W = 32
);
  logic             sig_in;
  logic             rise_pulse;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             timeout;
`ifdef PERIOD_METER_HIGH_EN
  logic [CNT_W-1:0] high_out;

  modport master (
    output sig_in,
    input  rise_pulse, period_out, period_valid, locked, timeout, high_out
  );

  modport slave (
    input  sig_in,
    output rise_pulse, period_out, period_valid, locked, timeout, high_out
  );
`else
  modport master (
    output sig_in,
    input  rise_pulse, period_out, period_valid, locked, timeout
  );

  modport slave (
    input  sig_in,
    output rise_pulse, period_out, period_valid, locked, timeout
  );
`endif
endinterface

// File: rtl/period_meter.sv
// Measures the period of a slow, asynchronous square wave in clk cycles.
// Reports each period with a one-cycle strobe, tracks lock and sticky loss of signal.
// Optional high-time measurement is enabled by defining PERIOD_METER_HIGH_EN.
module period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_CNT = 100000000
) (
  input  logic          clk,
  input  logic          rst,
  period_meter_if.slave bus
);

  typedef enum logic {StWaitFirst, StMeasure} state_e;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] One    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1, s2, s3;
  logic             rise;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             rise_pulse_q;
`ifdef PERIOD_METER_HIGH_EN
  logic             fall;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
`endif

  assign rise    = s2 & ~s3;
  assign cnt_inc = cnt_q + One;
`ifdef PERIOD_METER_HIGH_EN
  assign fall    = ~s2 & s3;
`endif

  // Synchronizer, edge register and registered rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      rise_pulse_q <= 1'b0;
    end else begin
      s1           <= bus.sig_in;
      s2           <= s1;
      s3           <= s2;
      rise_pulse_q <= rise;
    end
  end

  // Measurement state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StWaitFirst;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PERIOD_METER_HIGH_EN
      hcnt_q    <= '0;
      high_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
`ifdef PERIOD_METER_HIGH_EN
      hcnt_q    <= hcnt_d;
      high_q    <= high_d;
`endif
    end
  end

  // Next-state logic: a rise always wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
`ifdef PERIOD_METER_HIGH_EN
    hcnt_d    = hcnt_q;
    high_d    = high_q;
`endif
    unique case (state_q)
      StWaitFirst: begin
        cnt_d = '0;
        if (rise) begin
          state_d   = StMeasure;
          timeout_d = 1'b0;
`ifdef PERIOD_METER_HIGH_EN
          hcnt_d    = '0;
`endif
        end
      end
      StMeasure: begin
`ifdef PERIOD_METER_HIGH_EN
        // +1 accounts for the rise cycle itself, where hcnt is cleared.
        if (fall) high_d = hcnt_q + One;
        if (s2)   hcnt_d = hcnt_q + One;
`endif
        if (rise) begin
          period_d = cnt_inc;
          valid_d  = 1'b1;
          cnt_d    = '0;
          locked_d = 1'b1;
`ifdef PERIOD_METER_HIGH_EN
          hcnt_d   = '0;
`endif
        end else if (cnt_inc == MaxCnt) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          cnt_d     = '0;
          state_d   = StWaitFirst;
`ifdef PERIOD_METER_HIGH_EN
          hcnt_d    = '0;
          high_d    = '0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StWaitFirst;
    endcase
  end

  assign bus.rise_pulse   = rise_pulse_q;
  assign bus.period_out   = period_q;
  assign bus.period_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.timeout      = timeout_q;
`ifdef PERIOD_METER_HIGH_EN
  assign bus.high_out     = high_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed waveforms plus random ones,
// checked every cycle against a timestamp-based model of the wave's edges.
module tb_period_meter;

  localparam int unsigned CW  = 16;
  localparam int          MX  = 64;
  localparam int          HSZ = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  period_meter_if #(.CNT_W(CW)) bus ();

  period_meter #(
    .CNT_W  (CW),
    .MAX_CNT(MX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per-cycle history of sampled sig_in and timestamps of detected edges.
  bit hist [HSZ];
  int k = 2;
  bit armed = 1'b0;
  int last_rise = 0;
  int e_po = 0, e_hi = 0;
  bit e_pv = 0, e_rp = 0, e_lk = 0, e_to = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // An edge on sig_in sampled at edge j shows up on the outputs after edge j+2.
  task automatic model(input bit s, input bit r);
    bit rise, fall;
    if (r) begin
      hist[k] = 1'b0; hist[k-1] = 1'b0; hist[k-2] = 1'b0;
      armed = 1'b0;
      e_po = 0; e_hi = 0; e_pv = 0; e_rp = 0; e_lk = 0; e_to = 0;
      return;
    end
    hist[k] = s;
    rise = hist[k-2] && !hist[k-3];
    fall = !hist[k-2] && hist[k-3];
    e_rp = rise;
    e_pv = 1'b0;
    if (!armed) begin
      if (rise) begin
        armed = 1'b1;
        last_rise = k;
        e_to = 1'b0;
      end
    end else begin
      if (fall) e_hi = k - last_rise;
      if (rise) begin
        e_po = k - last_rise;
        e_pv = 1'b1;
        e_lk = 1'b1;
        last_rise = k;
      end else if (k - last_rise == MX) begin
        e_to = 1'b1;
        e_lk = 1'b0;
        armed = 1'b0;
        e_hi = 0;
      end
    end
  endtask

  task automatic tick(input bit s, input bit r);
    @(negedge clk);
    bus.sig_in = s;
    rst = r;
    @(posedge clk);
    k++;
    if (k >= HSZ) begin
      $display("FAIL cycle_budget: observed %0d cycles, expected fewer than %0d", k, HSZ);
      $fatal(1);
    end
    model(s, r);
    #1;
    chk("rise_pulse", int'(bus.rise_pulse), int'(e_rp));
    chk("period_valid", int'(bus.period_valid), int'(e_pv));
    chk("period_out", int'(bus.period_out), e_po);
    chk("locked", int'(bus.locked), int'(e_lk));
    chk("timeout", int'(bus.timeout), int'(e_to));
`ifdef PERIOD_METER_HIGH_EN
    chk("high_out", int'(bus.high_out), e_hi);
`endif
  endtask

  task automatic wave(input int hi, input int lo, input int n, input bit rnd_rst);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hi; i++) tick(1'b1, rnd_rst && ($urandom_range(0, 299) == 0));
      for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.sig_in = 1'b0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;

    // Reset.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Symmetric 4/4 wave.
    wave(4, 4, 6, 1'b0);
    chk("sq8_period", int'(bus.period_out), 8);
    chk("sq8_locked", int'(bus.locked), 1);

    // Asymmetric 3/7 wave.
    wave(3, 7, 4, 1'b0);
    chk("asym_period", int'(bus.period_out), 10);
`ifdef PERIOD_METER_HIGH_EN
    chk("asym_high", int'(bus.high_out), 3);
`endif

    // Lock on 8, then stuck low.
    wave(4, 4, 3, 1'b0);
    for (int i = 0; i < 80; i++) tick(1'b0, 1'b0);
    chk("stuck_timeout", int'(bus.timeout), 1);
    chk("stuck_locked", int'(bus.locked), 0);
    chk("stuck_period", int'(bus.period_out), 8);

    // Resume with period 12.
    wave(6, 6, 4, 1'b0);
    chk("resume_timeout", int'(bus.timeout), 0);
    chk("resume_period", int'(bus.period_out), 12);
    chk("resume_locked", int'(bus.locked), 1);

    // Reset mid-period while locked at 8.
    wave(4, 4, 3, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("rst_period", int'(bus.period_out), 0);
    chk("rst_valid", int'(bus.period_valid), 0);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_rise", int'(bus.rise_pulse), 0);
    wave(4, 4, 3, 1'b0);

    // Period exactly MAX_CNT: rise wins over timeout.
    wave(32, 32, 4, 1'b0);
    chk("max_period", int'(bus.period_out), 64);
    chk("max_timeout", int'(bus.timeout), 0);

    // Random waves, with occasional long stalls and sporadic resets.
    for (int t = 0; t < 40; t++) begin
      int hi, lo;
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 40);
      if ($urandom_range(0, 5) == 0) lo = $urandom_range(55, 90);
      if ($urandom_range(0, 9) == 0) hi = $urandom_range(60, 70);
      wave(hi, lo, 1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Receive-side companion to the slow toggling clock generators (e.g. the 1 s / 50%-duty square wave derived from the 50 MHz board clock).
- Samples a slow, possibly asynchronous square wave and measures its period in system-clock cycles.
- Reports each completed period with a one-cycle valid strobe and flags loss of signal.
- Used for self-check of divider outputs and for driving period readouts on the display path.

Parameters:
- CNT_W, 32, width of the cycle counter and of period_out.
- MAX_CNT, 100000000, timeout threshold in clk cycles (2 s at 50 MHz); must be below 2^CNT_W - 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  slow square wave under measurement; asynchronous to clk.
- rise_pulse  output  1  one-cycle pulse per detected rising edge of sig_in.
- period_out  output  CNT_W  last measured period in clk cycles; holds until the next measurement.
- period_valid  output  1  one-cycle strobe; period_out is updated in the same cycle.
- locked  output  1  high once at least one full period has been measured and no timeout has occurred since.
- timeout  output  1  sticky loss-of-signal flag.
- high_out  output  CNT_W  high-time in clk cycles; present only with PERIOD_METER_HIGH_EN.

Behaviour:
- Synchronizer:
  - Flops s1, s2 feed an edge register s3.
  - rise = s2 & ~s3.
  - A raw edge on sig_in appears on rise 2–3 cycles later, depending on sampling phase.
- rise_pulse is registered: it goes high the cycle after rise and is high for exactly 1 cycle per edge.
- Reset: on rst=1 at a clock edge, every register clears:
  - s1/s2/s3=0, cnt=0, state=WAIT_FIRST.
  - period_out=0, period_valid=0, rise_pulse=0, locked=0, timeout=0, high_out=0.
  - Reset mid-measurement discards the partial count; no period_valid is issued.
- State machine:
  - WAIT_FIRST:
    - cnt held at 0.
    - On rise: cnt<=0, timeout<=0, go to MEASURE.
    - No period_valid is issued for the first edge.
  - MEASURE: cnt<=cnt+1 each cycle.
    - On rise:
      - period_out<=cnt+1, period_valid<=1 (next cycle, 1 cycle wide), cnt<=0, locked<=1.
      - Stay in MEASURE.
    - If cnt+1 == MAX_CNT with no rise in that cycle:
      - timeout<=1, locked<=0, cnt<=0, go to WAIT_FIRST.
      - period_out retains its old value; no period_valid.
- Arithmetic:
  - The period is the count of clk cycles between consecutive rise detections.
  - cnt never exceeds MAX_CNT-1, so there is no wrap-around.
  - If rise and the timeout condition coincide, rise wins: the period is reported, with no timeout.
- Timeout stays set until the next rise (or rst); locked re-asserts only after the next full period.
- A constant sig_in (stuck 0 or stuck 1) produces a timeout after MAX_CNT cycles in MEASURE.
- Pulses narrower than one clk may be missed; no glitch filtering is applied.

Optional Feature:
- Macro: PERIOD_METER_HIGH_EN.
- Defined:
  - Adds a fall detect (~s2 & s3) and a high-time counter hcnt.
  - hcnt clears on rise and increments while s2=1 in MEASURE.
  - On fall, high_out<=hcnt; high_out is updated no later than the next period_valid.
  - high_out clears on rst and on timeout.
- Not defined:
  - high_out port is absent; no fall logic or hcnt is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset, then a square wave with high 4 / low 4 clk (MAX_CNT=64) -> first rise gives a rise_pulse only; from the second rise on, period_valid pulses every 8 cycles with period_out=8; locked=1 after the first period_valid.
- Asymmetric wave, high 3 / low 7 -> period_out=10; with PERIOD_METER_HIGH_EN, high_out=3.
- Lock on period 8, then hold sig_in low (MAX_CNT=64) -> timeout=1 and locked=0 exactly 64 cycles after the last rise; period_out stays 8; no period_valid.
- After timeout, resume period 12 -> timeout clears on the first rise, next period_valid reports 12, locked=1.
- Assert rst for 1 cycle mid-period while locked at 8 -> next cycle all outputs are 0; after restart, the first period_valid appears only after two further rises.
- Rise timed on the cycle cnt+1 reaches MAX_CNT (period exactly 64, MAX_CNT=64) -> period_valid with period_out=64, timeout stays 0.
